// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and counter transition for the branch target predictor
package bp_pkg;

  localparam logic [1:0] SN = 2'b00;
  localparam logic [1:0] WN = 2'b01;
  localparam logic [1:0] WT = 2'b10;
  localparam logic [1:0] ST = 2'b11;

  localparam int INSTR_BYTES = 4;

  // Jumps pin the counter to strongly taken; branches step with saturation.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken,
                                          input logic is_jump);
    if (is_jump) return ST;
    if (taken) return (ctr == ST) ? ST : ctr + 2'd1;
    return (ctr == SN) ? SN : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - saturating statistics counter
module bp_sat_counter #(
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              inc,
  output logic [STAT_W-1:0] count
);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count <= '0;
    end else if (inc && (count != {STAT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with 2-bit direction counters
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ENTRIES = 16,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              enable,
  input  logic              flush,
  input  logic [DATA_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [DATA_W-1:0] pred_next_pc,
  input  logic              update_valid,
  input  logic [DATA_W-1:0] update_pc,
  input  logic              update_is_jump,
  input  logic              update_taken,
  input  logic [DATA_W-1:0] update_target,
  input  logic              update_mispredict,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = DATA_W - IDX_W - 2;

  logic              valid_q  [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [DATA_W-1:0] target_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit, up_taken;
  logic             unused_pc_lsbs;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[DATA_W-1:IDX_W+2];
  assign up_idx = update_pc[IDX_W+1:2];
  assign up_tag = update_pc[DATA_W-1:IDX_W+2];
  assign unused_pc_lsbs = ^{lookup_pc[1:0], update_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle update is invisible here.
  assign pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken   = pred_hit && ctr_q[lk_idx][1];
  assign pred_next_pc = pred_taken ? target_q[lk_idx] : lookup_pc + DATA_W'(INSTR_BYTES);

  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  // A not-taken jump is illegal; treating it as taken keeps the table consistent.
  assign up_taken = update_taken || update_is_jump;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        ctr_q[i]    <= SN;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (enable) begin
      if (flush) begin
        for (int i = 0; i < ENTRIES; i++) begin
          valid_q[i] <= 1'b0;
        end
      end else if (update_valid) begin
        if (up_hit) begin
          ctr_q[up_idx] <= ctr_next(ctr_q[up_idx], up_taken, update_is_jump);
          if (up_taken) begin
            target_q[up_idx] <= update_target;
          end
        end else if (up_taken) begin
          valid_q[up_idx]  <= 1'b1;
          tag_q[up_idx]    <= up_tag;
          target_q[up_idx] <= update_target;
          ctr_q[up_idx]    <= update_is_jump ? ST : WT;
        end
      end
    end
  end

  bp_sat_counter #(.STAT_W(STAT_W)) u_stat_lookups (
    .clk   (clk),
    .arst  (arst),
    .inc   (enable),
    .count (stat_lookups)
  );

  bp_sat_counter #(.STAT_W(STAT_W)) u_stat_mispredicts (
    .clk   (clk),
    .arst  (arst),
    .inc   (enable && update_valid && update_mispredict),
    .count (stat_mispredicts)
  );

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - directed self-checking bench for branch_target_predictor
module tb_branch_target_predictor;

  localparam int DATA_W = 64;
  localparam int STAT_W = 4;

  logic              clk = 1'b0;
  logic              arst = 1'b0;
  logic              enable = 1'b0;
  logic              flush = 1'b0;
  logic [DATA_W-1:0] lookup_pc = '0;
  logic              pred_hit, pred_taken;
  logic [DATA_W-1:0] pred_next_pc;
  logic              update_valid = 1'b0;
  logic [DATA_W-1:0] update_pc = '0;
  logic              update_is_jump = 1'b0;
  logic              update_taken = 1'b0;
  logic [DATA_W-1:0] update_target = '0;
  logic              update_mispredict = 1'b0;
  logic [STAT_W-1:0] stat_lookups, stat_mispredicts;

  int n_cmp = 0;
  int n_fail = 0;

  branch_target_predictor #(.DATA_W(DATA_W), .ENTRIES(16), .STAT_W(STAT_W)) dut (
    .clk               (clk),
    .arst              (arst),
    .enable            (enable),
    .flush             (flush),
    .lookup_pc         (lookup_pc),
    .pred_hit          (pred_hit),
    .pred_taken        (pred_taken),
    .pred_next_pc      (pred_next_pc),
    .update_valid      (update_valid),
    .update_pc         (update_pc),
    .update_is_jump    (update_is_jump),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .update_mispredict (update_mispredict),
    .stat_lookups      (stat_lookups),
    .stat_mispredicts  (stat_mispredicts)
  );

  always #5 clk = ~clk;

  // The bench must never issue a not-taken jump.
  always @(posedge clk) begin
    if (enable && update_valid) begin
      assert (!(update_is_jump && !update_taken))
        else $error("illegal not-taken jump driven");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [DATA_W-1:0] pc);
    lookup_pc = pc;
    #1;
  endtask

  task automatic do_update(input logic [DATA_W-1:0] pc, input logic jump, input logic taken,
                           input logic [DATA_W-1:0] tgt);
    update_valid   = 1'b1;
    update_pc      = pc;
    update_is_jump = jump;
    update_taken   = taken;
    update_target  = tgt;
    step();
    update_valid   = 1'b0;
  endtask

  task automatic chk_look(input string name, input logic [DATA_W-1:0] pc, input logic hit,
                          input logic tk, input logic [DATA_W-1:0] npc);
    look(pc);
    n_cmp++;
    if ({pred_hit, pred_taken, pred_next_pc} !== {hit, tk, npc}) begin
      n_fail++;
      $display("FAIL %s: got hit=%b taken=%b next=%h want hit=%b taken=%b next=%h",
               name, pred_hit, pred_taken, pred_next_pc, hit, tk, npc);
    end
  endtask

  task automatic pulse_reset();
    #1 arst = 1'b1;
    #2 arst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    enable = 1'b1;
    chk_look("reset_lookup", 64'h100, 1'b0, 1'b0, 64'h104);
    n_cmp++;
    if ({stat_lookups, stat_mispredicts} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_lookups, stat_mispredicts);
    end
  endtask

  task automatic test_branch_train();
    do_update(64'h100, 1'b0, 1'b1, 64'h40);
    chk_look("br_alloc_wt", 64'h100, 1'b1, 1'b1, 64'h40);
    do_update(64'h100, 1'b0, 1'b0, 64'h999);
    chk_look("br_wn", 64'h100, 1'b1, 1'b0, 64'h104);
    do_update(64'h100, 1'b0, 1'b0, 64'h999);
    chk_look("br_sn", 64'h100, 1'b1, 1'b0, 64'h104);
    do_update(64'h100, 1'b0, 1'b1, 64'h44);
    chk_look("br_sn_to_wn", 64'h100, 1'b1, 1'b0, 64'h104);
    do_update(64'h100, 1'b0, 1'b1, 64'h48);
    chk_look("br_wn_to_wt", 64'h100, 1'b1, 1'b1, 64'h48);
    chk_look("pc_lsbs_ignored", 64'h103, 1'b1, 1'b1, 64'h48);
  endtask

  task automatic test_alias();
    do_update(64'h140, 1'b0, 1'b1, 64'h80);
    chk_look("alias_old_miss", 64'h100, 1'b0, 1'b0, 64'h104);
    chk_look("alias_new_hit", 64'h140, 1'b1, 1'b1, 64'h80);
  endtask

  task automatic test_jump_saturate();
    do_update(64'h200, 1'b1, 1'b1, 64'h800);
    chk_look("jmp_st", 64'h200, 1'b1, 1'b1, 64'h800);
    do_update(64'h200, 1'b0, 1'b0, 64'h0);
    chk_look("jmp_wt", 64'h200, 1'b1, 1'b1, 64'h800);
    do_update(64'h200, 1'b0, 1'b0, 64'h0);
    chk_look("jmp_wn", 64'h200, 1'b1, 1'b0, 64'h204);
    do_update(64'h200, 1'b0, 1'b0, 64'h0);
    do_update(64'h200, 1'b0, 1'b0, 64'h0);
    do_update(64'h200, 1'b0, 1'b1, 64'h810);
    // From a saturated SN, one taken gives WN: still predicted not taken.
    chk_look("sn_saturates", 64'h200, 1'b1, 1'b0, 64'h204);
    do_update(64'h200, 1'b1, 1'b1, 64'h900);
    chk_look("jmp_hit_st", 64'h200, 1'b1, 1'b1, 64'h900);
  endtask

  task automatic test_back_to_back();
    update_valid = 1'b1; update_pc = 64'h104; update_is_jump = 1'b0;
    update_taken = 1'b1; update_target = 64'hABC0;
    chk_look("no_bypass_pre", 64'h104, 1'b0, 1'b0, 64'h108);
    step();
    update_valid = 1'b0;
    chk_look("no_bypass_post", 64'h104, 1'b1, 1'b1, 64'hABC0);
    chk_look("wrap_add", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic test_flush();
    do_update(64'h100, 1'b0, 1'b1, 64'h40);
    do_update(64'h108, 1'b0, 1'b1, 64'h60);
    chk_look("pre_flush_hit", 64'h108, 1'b1, 1'b1, 64'h60);
    flush = 1'b1;
    do_update(64'h300, 1'b0, 1'b1, 64'h70);
    flush = 1'b0;
    chk_look("flush_drop_upd", 64'h300, 1'b0, 1'b0, 64'h304);
    chk_look("flush_100", 64'h100, 1'b0, 1'b0, 64'h104);
    chk_look("flush_108", 64'h108, 1'b0, 1'b0, 64'h10C);
  endtask

  task automatic test_enable_gate();
    do_update(64'h10C, 1'b0, 1'b1, 64'h90);
    enable = 1'b0;
    flush  = 1'b1;
    do_update(64'h110, 1'b1, 1'b1, 64'hA0);
    flush  = 1'b0;
    chk_look("gated_flush", 64'h10C, 1'b1, 1'b1, 64'h90);
    chk_look("gated_update", 64'h110, 1'b0, 1'b0, 64'h114);
    enable = 1'b1;
  endtask

  task automatic test_stats();
    pulse_reset();
    n_cmp++;
    if ({stat_lookups, stat_mispredicts} !== 8'h00) begin
      n_fail++;
      $display("FAIL stats_cleared: got %0d/%0d want 0/0", stat_lookups, stat_mispredicts);
    end
    enable = 1'b1;
    update_pc = 64'h500; update_is_jump = 1'b0; update_taken = 1'b0;
    update_valid = 1'b1; update_mispredict = 1'b1;
    for (int i = 0; i < 3; i++) step();
    update_mispredict = 1'b0;
    for (int i = 0; i < 2; i++) step();
    n_cmp++;
    if ({stat_lookups, stat_mispredicts} !== {4'd5, 4'd3}) begin
      n_fail++;
      $display("FAIL stats_count: got %0d/%0d want 5/3", stat_lookups, stat_mispredicts);
    end
    enable = 1'b0;
    update_mispredict = 1'b1;
    for (int i = 0; i < 2; i++) step();
    n_cmp++;
    if ({stat_lookups, stat_mispredicts} !== {4'd5, 4'd3}) begin
      n_fail++;
      $display("FAIL stats_gated: got %0d/%0d want 5/3", stat_lookups, stat_mispredicts);
    end
    enable = 1'b1;
    for (int i = 0; i < 15; i++) step();
    n_cmp++;
    if ({stat_lookups, stat_mispredicts} !== {4'd15, 4'd15}) begin
      n_fail++;
      $display("FAIL stats_saturate: got %0d/%0d want 15/15", stat_lookups, stat_mispredicts);
    end
    enable = 1'b0;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if ({stat_lookups, stat_mispredicts} !== {4'd15, 4'd15}) begin
      n_fail++;
      $display("FAIL stats_hold: got %0d/%0d want 15/15", stat_lookups, stat_mispredicts);
    end
    enable = 1'b1;
    update_valid = 1'b0;
    update_mispredict = 1'b0;
    chk_look("miss_not_taken_noalloc", 64'h500, 1'b0, 1'b0, 64'h504);
  endtask

  task automatic test_async_reset();
    do_update(64'h100, 1'b0, 1'b1, 64'h40);
    chk_look("pre_arst_hit", 64'h100, 1'b1, 1'b1, 64'h40);
    #2 arst = 1'b1;
    #1;
    n_cmp++;
    if ({pred_hit, pred_taken, pred_next_pc, stat_lookups} !== {1'b0, 1'b0, 64'h104, 4'd0}) begin
      n_fail++;
      $display("FAIL async_reset: got hit=%b taken=%b next=%h lookups=%0d want 0 0 104 0",
               pred_hit, pred_taken, pred_next_pc, stat_lookups);
    end
    arst = 1'b0;
  endtask

  initial begin
    step();
    test_reset();
    test_branch_train();
    test_alias();
    test_jump_saturate();
    test_back_to_back();
    test_flush();
    test_enable_gate();
    test_stats();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
